aclk_key_entry: RTL
===================

# aclk_key_entry

Keypad entry controller for the alarm clock. It sits directly upstream of the LCD display stage. It samples the debounced keypad code every clock and runs the entry state machine. It buffers typed digits in a four-digit shift register (`key_ms_hr`..`key_ls_min`) and drives the display-select strobes (`show_new_time`, `show_a`). It also generates load strobes for the alarm register and the time counter, and abandons a stale entry after an inactivity timeout.

## Interface
- `TIMEOUT_SEC`, default 10: number of `one_second` pulses of keypad inactivity after which an entry is abandoned; legal range 1..255.
- `clock`  input  1: single system clock; all state changes on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `one_second`  input  1: one-cycle pulse per second from the time base.
- `key`  input  4: debounced keypad code, synchronous to `clock`.
  - 0–9 are digits; 10 is ALARM; 11 is TIME; 15 is NOKEY.
  - 12–14 are treated exactly as NOKEY.
- `key_ms_hr`, `key_ls_hr`, `key_ms_min`, `key_ls_min`  output  4 each: buffered entry digits, feeding the display stage and the alarm/time loaders.
- `show_new_time`  output  1: display shows the key buffer.
- `show_a`  output  1: display shows the alarm time.
- `load_new_a`  output  1: one-cycle strobe; alarm register loads the key buffer.
- `load_new_c`  output  1: one-cycle strobe; current-time counter loads the key buffer.
- `reset_count`  output  1: one-cycle strobe, coincident with `load_new_c`; clears the seconds prescaler.

## Operation
- The FSM has 7 states: SHOW_TIME, SHOW_ALARM, KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_ALARM_TIME, SET_CURRENT_TIME.
- All outputs are Moore outputs, decoded from the state register or taken directly from the buffer registers.
- Transitions (evaluated every edge):
  - SHOW_TIME: ALARM goes to SHOW_ALARM; a digit goes to KEY_STORED; anything else stays.
  - SHOW_ALARM: NOKEY goes to SHOW_TIME; anything else stays, so the alarm is shown for as long as the ALARM key is held.
  - KEY_STORED: always goes to KEY_WAITED.
  - KEY_WAITED: timeout goes to SHOW_TIME; otherwise NOKEY goes to KEY_ENTRY; otherwise stays. A held or changed key without release is ignored.
  - KEY_ENTRY:
    - a digit goes to KEY_STORED, ALARM goes to SET_ALARM_TIME, and TIME goes to SET_CURRENT_TIME;
    - with no key event, timeout goes to SHOW_TIME; a key event has priority over a simultaneous timeout;
    - otherwise stays.
  - SET_ALARM_TIME and SET_CURRENT_TIME: always go to SHOW_TIME.
- Output decode:
  - `show_new_time` = 1 in KEY_STORED, KEY_WAITED and KEY_ENTRY.
  - `show_a` = 1 in SHOW_ALARM.
  - `load_new_a` = 1 in SET_ALARM_TIME.
  - `load_new_c` = `reset_count` = 1 in SET_CURRENT_TIME.
- Key buffer updates only on the edge that enters KEY_STORED:
  - From SHOW_TIME: the buffer is cleared and the digit lands in `key_ls_min`, giving 0,0,0,d.
  - From KEY_ENTRY: the buffer shifts left (ms_hr←ls_hr, ls_hr←ms_min, ms_min←ls_min, ls_min←digit). The oldest digit is discarded, so after more than 4 digits the last 4 are kept.
  - The buffer holds its value in every other state, including after a load or a timeout.
- No range checking of digits (e.g. 29:75) is done; the buffer passes values unmodified.
- Timeout counter:
  - Width is ceil(log2(TIMEOUT_SEC+1)).
  - Cleared on reset and on every edge whose state is SHOW_TIME, SHOW_ALARM or KEY_STORED.
  - Increments on `one_second` while in KEY_WAITED or KEY_ENTRY, and saturates at TIMEOUT_SEC.
  - `timeout` = (count == TIMEOUT_SEC), decoded combinationally.

## Timing
- Reset (async assert, sync-clean deassert assumed upstream): state SHOW_TIME, all key digits 0, counter 0, and every output 0.
- Reset asserted mid-entry aborts the entry immediately; the buffer clears to 0 and no load strobe is produced.
- Latency, digit in SHOW_TIME:
  - key sampled at edge n;
  - after edge n, `key_ls_min` = d and `show_new_time` = 1;
  - after edge n+1, state is KEY_WAITED.
- Load strobes:
  - ALARM or TIME sampled in KEY_ENTRY at edge n gives a strobe high for exactly the cycle after edge n.
  - The state is SHOW_TIME after edge n+1.
  - The buffer is stable during the strobe.
- Timeout:
  - Occurs on the TIMEOUT_SEC-th `one_second` pulse counted since the last KEY_STORED.
  - The transition to SHOW_TIME happens at the first edge with `timeout` = 1.
  - No strobe is issued on timeout.
- A `one_second` pulse coincident with a digit in KEY_ENTRY is not counted, because the counter clears on entry to KEY_STORED.

## Test plan
- Reset with key=15, then release `reset_n` → all outputs 0 and state SHOW_TIME; assert `reset_n` low in KEY_ENTRY → outputs 0 asynchronously.
- Key sequence 1, 15, 2, 15, 3, 15, 0, 15, 11 → buffer 1,2,3,0; `load_new_c` and `reset_count` each high for exactly 1 cycle; `show_new_time` falls the cycle after.
- Key sequence 0, 15, 6, 15, 3, 15, 0, 15, 10 → buffer 0,6,3,0 and one `load_new_a` pulse. Then hold key=10 for 20 cycles → `show_a` = 1 for those cycles and drops 1 cycle after key=15.
- Enter digits 1,2,3,4,5 (each followed by 15) → buffer 2,3,4,5; holding digit 7 for 50 cycles in KEY_WAITED → only one shift.
- TIMEOUT_SEC=3: enter 9, 15, then give 3 `one_second` pulses → return to SHOW_TIME at the third pulse with no strobe. Repeat with digit 4 coincident with the third pulse → KEY_STORED, not a timeout.
- Codes 12–14 in every state behave as NOKEY; TIME pressed in SHOW_TIME → no state change.

Source files
------------

// File: rtl/aclk_key_entry.sv
// Alarm-clock keypad entry controller: buffers up to four typed digits, drives display
// select strobes, issues alarm/time load strobes and abandons stale entries on timeout.
module aclk_key_entry #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       one_second,
  input  logic [3:0] key,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count
);

  localparam int unsigned CntW = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_SEC);

  localparam logic [2:0] StShowTime    = 3'd0;
  localparam logic [2:0] StShowAlarm   = 3'd1;
  localparam logic [2:0] StKeyStored   = 3'd2;
  localparam logic [2:0] StKeyWaited   = 3'd3;
  localparam logic [2:0] StKeyEntry    = 3'd4;
  localparam logic [2:0] StSetAlarm    = 3'd5;
  localparam logic [2:0] StSetCurrent  = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  logic [3:0]      ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;

  logic is_digit, is_alarm, is_time, is_nokey, timeout;

  // Codes 12..14 are unused keypad codes and behave exactly like NOKEY.
  assign is_digit = (key <= 4'd9);
  assign is_alarm = (key == 4'd10);
  assign is_time  = (key == 4'd11);
  assign is_nokey = (key >= 4'd12);
  assign timeout  = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StShowTime: begin
        if (is_alarm)      state_d = StShowAlarm;
        else if (is_digit) state_d = StKeyStored;
      end
      StShowAlarm: begin
        if (is_nokey) state_d = StShowTime;
      end
      StKeyStored: state_d = StKeyWaited;
      StKeyWaited: begin
        if (timeout)       state_d = StShowTime;
        else if (is_nokey) state_d = StKeyEntry;
      end
      StKeyEntry: begin
        // A key event wins over a timeout landing on the same edge.
        if (is_digit)      state_d = StKeyStored;
        else if (is_alarm) state_d = StSetAlarm;
        else if (is_time)  state_d = StSetCurrent;
        else if (timeout)  state_d = StShowTime;
      end
      StSetAlarm:   state_d = StShowTime;
      StSetCurrent: state_d = StShowTime;
      default:      state_d = StShowTime;
    endcase
  end

  // Buffer only moves on the edge that enters KEY_STORED; KEY_STORED never self-loops.
  always_comb begin
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
    if (state_d == StKeyStored) begin
      if (state_q == StShowTime) begin
        ms_hr_d  = 4'd0;
        ls_hr_d  = 4'd0;
        ms_min_d = 4'd0;
        ls_min_d = key;
      end else begin
        ms_hr_d  = ls_hr_q;
        ls_hr_d  = ms_min_q;
        ms_min_d = ls_min_q;
        ls_min_d = key;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      StShowTime, StShowAlarm, StKeyStored: cnt_d = '0;
      StKeyWaited, StKeyEntry: begin
        if (one_second && (cnt_q != CntMax)) cnt_d = cnt_q + CntW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StShowTime;
      cnt_q    <= '0;
      ms_hr_q  <= 4'd0;
      ls_hr_q  <= 4'd0;
      ms_min_q <= 4'd0;
      ls_min_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
    end
  end

  assign key_ms_hr     = ms_hr_q;
  assign key_ls_hr     = ls_hr_q;
  assign key_ms_min    = ms_min_q;
  assign key_ls_min    = ls_min_q;
  assign show_new_time = (state_q == StKeyStored) || (state_q == StKeyWaited) ||
                         (state_q == StKeyEntry);
  assign show_a        = (state_q == StShowAlarm);
  assign load_new_a    = (state_q == StSetAlarm);
  assign load_new_c    = (state_q == StSetCurrent);
  assign reset_count   = (state_q == StSetCurrent);

endmodule
